// File: rtl/relu_quant_pool.sv
// ReLU + rounding requantisation + saturation, then 2x2 stride-2 max pooling over a raster stream.
// Define RELU_QUANT_POOL_BYPASS_EN to drop pooling and forward every quantised pixel.
module relu_quant_pool #(
  parameter int unsigned WDP_Q       = 17,
  parameter int unsigned WDP         = 9,
  parameter int unsigned QUANT_SHIFT = 4,
  parameter int unsigned FM_W        = 24,
  parameter int unsigned FM_H        = 24
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    d_en,
  input  logic signed [WDP_Q-1:0] d,
  output logic                    q_en,
  output logic [WDP-1:0]          q,
  output logic                    frame_done
);

  if ((FM_W % 2) != 0 || FM_W < 2 || (FM_H % 2) != 0 || FM_H < 2 || QUANT_SHIFT == 0)
  begin : gen_param_err
    $error("relu_quant_pool: FM_W/FM_H must be even and >= 2, QUANT_SHIFT must be >= 1");
  end

  localparam int unsigned ColW = (FM_W > 2) ? $clog2(FM_W) : 1;
  localparam int unsigned RowW = (FM_H > 2) ? $clog2(FM_H) : 1;

  localparam logic [WDP_Q:0] RndAdd  = (WDP_Q+1)'(1) << (QUANT_SHIFT - 1);
  localparam logic [WDP_Q:0] MaxWide = (WDP_Q+1)'((1 << (WDP - 1)) - 1);
  localparam logic [WDP-1:0] MaxQ    = WDP'((1 << (WDP - 1)) - 1);

  logic [WDP_Q:0]  rnd, shifted;
  logic [WDP-1:0]  quant;
  logic            v1_d, v1_q;
  logic [WDP-1:0]  val_d, val_q;
  logic [ColW-1:0] col_d, col_q;
  logic [RowW-1:0] row_d, row_q;
  logic            col_last, row_last;
  logic [WDP-1:0]  out_d, out_q;
  logic            out_en_d, out_en_q;
  logic            fd_d, fd_q;

  // Rounding add is done one bit wider so the largest positive input cannot wrap.
  always_comb begin
    rnd     = {1'b0, d} + RndAdd;
    shifted = rnd >> QUANT_SHIFT;
    if (d[WDP_Q-1]) begin
      quant = '0;
    end else if (shifted > MaxWide) begin
      quant = MaxQ;
    end else begin
      quant = shifted[WDP-1:0];
    end
  end

  always_comb begin
    v1_d  = d_en & ~clr;
    val_d = (d_en & ~clr) ? quant : val_q;
  end

  assign col_last = (col_q == ColW'(FM_W - 1));
  assign row_last = (row_q == RowW'(FM_H - 1));

  // Counters track the position of the pixel currently held in stage 1.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (v1_q) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

`ifdef RELU_QUANT_POOL_BYPASS_EN
  always_comb begin
    out_d    = out_q;
    out_en_d = 1'b0;
    fd_d     = 1'b0;
    if (!clr && v1_q) begin
      out_d    = val_q;
      out_en_d = 1'b1;
      fd_d     = row_last && col_last;
    end
  end
`else
  localparam int unsigned LbW = (ColW > 1) ? ColW - 1 : 1;
  localparam int unsigned LbD = FM_W / 2;

  logic [WDP-1:0] hold_d, hold_q;
  logic [WDP-1:0] lb_q [LbD];
  logic [LbW-1:0] lb_idx;
  logic [WDP-1:0] lb_rd, pair_max;
  logic           lb_we;

  always_comb begin
    lb_idx   = LbW'(col_q >> 1);
    lb_rd    = lb_q[lb_idx];
    pair_max = (hold_q > val_q) ? hold_q : val_q;
    hold_d   = hold_q;
    lb_we    = 1'b0;
    out_d    = out_q;
    out_en_d = 1'b0;
    fd_d     = 1'b0;
    if (clr) begin
      hold_d = '0;
    end else if (v1_q) begin
      if (!col_q[0]) begin
        hold_d = val_q;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_d    = (pair_max > lb_rd) ? pair_max : lb_rd;
        out_en_d = 1'b1;
        fd_d     = row_last && col_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Even rows always fill an entry before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= pair_max;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q     <= 1'b0;
      val_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      out_q    <= '0;
      out_en_q <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      val_q    <= val_d;
      col_q    <= col_d;
      row_q    <= row_d;
      out_q    <= out_d;
      out_en_q <= out_en_d;
      fd_q     <= fd_d;
    end
  end

  assign q          = out_q;
  assign q_en       = out_en_q;
  assign frame_done = fd_q;

endmodule
